// File: rtl/reg_load_skid_buffer.sv
// Two-entry valid/ready skid buffer feeding the 32-bit Register stage; 1-cycle latency when empty.
// in_ready depends on state only, so out_ready back-pressure is absorbed by the skid entry with no comb path.
module reg_load_skid_buffer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              reg_load,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_dat;
  logic [DATA_W-1:0] skid_dat;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = reset & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign reg_load  = out_fire;
  assign out_data  = main_dat;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= EMPTY;
      occupancy  <= 2'd0;
      main_dat   <= '0;
      skid_dat   <= '0;
      xfer_count <= '0;
    end else begin
      if (out_fire) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_dat  <= in_data;
            state     <= ONE;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_dat <= in_data;
          end else if (in_fire) begin
            skid_dat  <= in_data;
            state     <= FULL;
            occupancy <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            occupancy <= 2'd0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can move data.
          if (out_fire) begin
            main_dat  <= skid_dat;
            state     <= ONE;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_load_skid_buffer.sv
// Directed bench for reg_load_skid_buffer with a 4-bit transfer counter and an in-order scoreboard.
module tb_reg_load_skid_buffer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              reg_load;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  xfer_count;

  int n_vec = 0;
  int n_err = 0;
  int pop_cnt = 0;
  logic [DATA_W-1:0] sb_q[$];

  reg_load_skid_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .reg_load   (reg_load),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Inputs only change shortly after a rising edge, so at the falling edge they show
  // exactly what the next rising edge will sample.
  always @(negedge clock) begin
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (reg_load) begin
        if (sb_q.size() == 0) begin
          chk("spurious_load", 32'd1, 32'd0);
        end else begin
          chk("order", out_data, sb_q.pop_front());
        end
        pop_cnt++;
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  initial begin
    int sent;
    int budget;

    // 1) reset with a live producer
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_xfer", {28'd0, xfer_count}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 2) pass-through at full rate
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5A5A5;
    tick();
    chk("pt_data0", out_data, 32'hA5A5A5A5);
    chk("pt_load0", {31'd0, reg_load}, 32'd1);
    chk("pt_occ0", {30'd0, occupancy}, 32'd1);
    in_data = 32'h5A5A5A5A;
    tick();
    chk("pt_data1", out_data, 32'h5A5A5A5A);
    chk("pt_occ1", {30'd0, occupancy}, 32'd1);
    chk("pt_xfer1", {28'd0, xfer_count}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("pt_xfer2", {28'd0, xfer_count}, 32'd2);
    chk("pt_empty", {31'd0, out_valid}, 32'd0);

    // 3) back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    tick();
    chk("bp_occ_full", {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 32'h33333333;
    tick();
    chk("bp_hold_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_hold_data", out_data, 32'h11111111);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_drain_load", {31'd0, reg_load}, 32'd1);
    tick();
    chk("bp_drain_data1", out_data, 32'h22222222);
    chk("bp_drain_occ1", {30'd0, occupancy}, 32'd1);
    tick();
    chk("bp_drain_occ0", {30'd0, occupancy}, 32'd0);
    chk("bp_xfer", {28'd0, xfer_count}, 32'd4);
    out_ready = 1'b0;

    // 4) simultaneous accept and transfer in ONE
    in_valid = 1'b1; in_data = 32'h12345678;
    tick();
    in_data = 32'h9ABCDEF0; out_ready = 1'b1;
    #1;
    chk("sim_head", out_data, 32'h12345678);
    tick();
    chk("sim_new_head", out_data, 32'h9ABCDEF0);
    chk("sim_occ", {30'd0, occupancy}, 32'd1);
    chk("sim_xfer", {28'd0, xfer_count}, 32'd5);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // 5) reset while FULL
    in_valid = 1'b1; in_data = 32'hAAAA0001;
    tick();
    in_data = 32'hAAAA0002;
    tick();
    chk("mid_full", {30'd0, occupancy}, 32'd2);
    in_valid = 1'b0; reset = 1'b0;
    #1;
    chk("mid_no_load", {31'd0, reg_load}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("mid_occ", {30'd0, occupancy}, 32'd0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_xfer", {28'd0, xfer_count}, 32'd0);
    chk("mid_out_data", out_data, 32'h0);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    tick();
    in_valid = 1'b0;
    chk("mid_first", out_data, 32'hCAFEF00D);
    out_ready = 1'b1;
    tick();
    chk("mid_first_xfer", {28'd0, xfer_count}, 32'd1);
    out_ready = 1'b0;

    // 6) 17 transfers with random stalls wrap the 4-bit counter to 1
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pop_cnt = 0; sent = 0; budget = 2000;
    while (pop_cnt < 17 && budget > 0) begin
      in_valid  = (sent < 17) && ($urandom_range(0, 3) != 0);
      in_data   = 32'h60000000 + sent;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      @(posedge clock);
      #1;
      budget--;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_pops", pop_cnt, 32'd17);
    chk("wrap_xfer", {28'd0, xfer_count}, 32'd1);
    chk("wrap_leftover", sb_q.size(), 32'd0);
    chk("wrap_occ", {30'd0, occupancy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
